// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the elevator car controller.
package elevator_pkg;

  localparam int FLOOR_WIDTH   = 4;
  localparam int NUM_FLOORS    = 16;
  localparam int TRAVEL_CYCLES = 8;
  localparam int DOOR_CYCLES   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETTLE,
    ST_MOVE_UP,
    ST_MOVE_DOWN,
    ST_DOOR_OPEN
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter shared by floor-travel and door-open timing.
// done_o is high on the last counted cycle so the owner can reload on that edge.
module elevator_timer #(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     cnt_q <= '0;
    else if (load_i)                 cnt_q <= load_val_i;
    else if (en_i && cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/elevator_fsm.sv
// Elevator car sequencer: fetch target, travel floor by floor, open door.
// Optional ELEVATOR_FSM_DOOR_HOLD_EN adds i_door_hold to keep the door open.
module elevator_fsm
  import elevator_pkg::*;
#(
  parameter int FSM_FLOOR_WIDTH = FLOOR_WIDTH,
  parameter int NUM_FLOORS      = elevator_pkg::NUM_FLOORS,
  parameter int TRAVEL_CYCLES   = elevator_pkg::TRAVEL_CYCLES,
  parameter int DOOR_CYCLES     = elevator_pkg::DOOR_CYCLES
) (
  input  logic                       i_clock,
  input  logic                       i_rst_n,
  input  logic                       i_req_valid,
  input  logic                       i_fsm_move_up,
  input  logic                       i_fsm_move_down,
  input  logic                       i_fsm_equal,
`ifdef ELEVATOR_FSM_DOOR_HOLD_EN
  input  logic                       i_door_hold,
`endif
  output logic                       o_rd_en,
  output logic [FSM_FLOOR_WIDTH-1:0] o_current_floor,
  output logic                       o_motor_up,
  output logic                       o_motor_down,
  output logic                       o_door_open,
  output logic                       o_busy,
  output logic                       o_fault
);

  localparam int CNT_W = $clog2(max2(TRAVEL_CYCLES, DOOR_CYCLES) + 1);
  localparam logic [CNT_W-1:0] TRAVEL_LD = CNT_W'(TRAVEL_CYCLES);
  localparam logic [CNT_W-1:0] DOOR_LD   = CNT_W'(DOOR_CYCLES);
  localparam logic [FSM_FLOOR_WIDTH-1:0] TOP_FLOOR = FSM_FLOOR_WIDTH'(NUM_FLOORS - 1);

  state_e                     state_q, state_d;
  logic [FSM_FLOOR_WIDTH-1:0] floor_q, floor_d;
  logic                       tmr_load, tmr_en, tmr_done;
  logic [CNT_W-1:0]           tmr_val;
  logic                       cmp_ok, door_hold;

  assign cmp_ok = $onehot({i_fsm_move_up, i_fsm_move_down, i_fsm_equal});

`ifdef ELEVATOR_FSM_DOOR_HOLD_EN
  assign door_hold = i_door_hold;
`else
  assign door_hold = 1'b0;
`endif

  elevator_timer #(.W(CNT_W)) u_timer (
    .clk_i      (i_clock),
    .rst_ni     (i_rst_n),
    .load_i     (tmr_load),
    .en_i       (tmr_en),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      floor_q <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
    end
  end

  // Outputs are decoded from the state so reset clears them combinationally.
  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;
    tmr_val      = TRAVEL_LD;
    o_rd_en      = 1'b0;
    o_motor_up   = 1'b0;
    o_motor_down = 1'b0;
    o_door_open  = 1'b0;
    o_fault      = 1'b0;
    o_busy       = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: if (i_req_valid) state_d = ST_FETCH;
      ST_FETCH: begin
        o_rd_en = 1'b1;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        tmr_load = 1'b1;
        if (!cmp_ok) begin
          o_fault = 1'b1;
          state_d = ST_IDLE;
        end else if (i_fsm_equal) begin
          tmr_val = DOOR_LD;
          state_d = ST_DOOR_OPEN;
        end else if (i_fsm_move_up) begin
          state_d = ST_MOVE_UP;
        end else begin
          state_d = ST_MOVE_DOWN;
        end
      end
      ST_MOVE_UP: begin
        if (!cmp_ok) begin
          o_fault = 1'b1;
          state_d = ST_IDLE;
        end else if (i_fsm_equal) begin
          tmr_load = 1'b1;
          tmr_val  = DOOR_LD;
          state_d  = ST_DOOR_OPEN;
        end else if (i_fsm_move_down) begin
          tmr_load = 1'b1;
          state_d  = ST_MOVE_DOWN;
        end else if (floor_q == TOP_FLOOR) begin
          // Target beyond the shaft: stop here rather than wrap.
          o_fault  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = DOOR_LD;
          state_d  = ST_DOOR_OPEN;
        end else begin
          o_motor_up = 1'b1;
          tmr_en     = 1'b1;
          if (tmr_done) begin
            tmr_load = 1'b1;
            floor_d  = floor_q + 1'b1;
          end
        end
      end
      ST_MOVE_DOWN: begin
        if (!cmp_ok) begin
          o_fault = 1'b1;
          state_d = ST_IDLE;
        end else if (i_fsm_equal) begin
          tmr_load = 1'b1;
          tmr_val  = DOOR_LD;
          state_d  = ST_DOOR_OPEN;
        end else if (i_fsm_move_up) begin
          tmr_load = 1'b1;
          state_d  = ST_MOVE_UP;
        end else if (floor_q == '0) begin
          o_fault  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = DOOR_LD;
          state_d  = ST_DOOR_OPEN;
        end else begin
          o_motor_down = 1'b1;
          tmr_en       = 1'b1;
          if (tmr_done) begin
            tmr_load = 1'b1;
            floor_d  = floor_q - 1'b1;
          end
        end
      end
      ST_DOOR_OPEN: begin
        o_door_open = 1'b1;
        tmr_val     = DOOR_LD;
        if (door_hold) begin
          tmr_load = 1'b1;
        end else begin
          tmr_en = 1'b1;
          if (tmr_done) state_d = i_req_valid ? ST_FETCH : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_current_floor = floor_q;

endmodule

// File: doc/elevator_fsm.md
ELEVATOR_FSM -- requirements
Module: elevator_fsm

Interface
REQ-001 SHALL have parameter FSM_FLOOR_WIDTH, default 4, width of floor number.
REQ-002 SHALL have parameter NUM_FLOORS, default 16, floors 0..NUM_FLOORS-1.
REQ-003 SHALL have parameter TRAVEL_CYCLES, default 8, clock cycles to travel one floor, >=1.
REQ-004 SHALL have parameter DOOR_CYCLES, default 16, clock cycles door stays open, >=1.
REQ-005 SHALL have port i_clock  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port i_req_valid  input  1  request queue holds at least one floor request.
REQ-008 SHALL have ports i_fsm_move_up, i_fsm_move_down, i_fsm_equal  input  1 each  one-hot target-versus-current comparison from the floor controller.
REQ-009 SHALL have port o_rd_en  output  1  one-cycle pulse; controller latches next requested floor on that edge.
REQ-010 SHALL have port o_current_floor  output  FSM_FLOOR_WIDTH  registered car position, fed back to the controller.
REQ-011 SHALL have ports o_motor_up, o_motor_down  output  1 each  motor drive.
REQ-012 SHALL have ports o_door_open  output  1, o_busy  output  1, o_fault  output  1 (one-cycle pulse).

Function
REQ-013 States: IDLE, FETCH, SETTLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
REQ-014 IDLE: i_req_valid=1 -> FETCH; else stay; o_busy=0 only in IDLE.
REQ-015 FETCH: o_rd_en=1 for exactly one cycle -> SETTLE; o_rd_en=0 in every other state.
REQ-016 SETTLE (comparison now reflects new target): equal -> DOOR_OPEN; up -> MOVE_UP; down -> MOVE_DOWN.
REQ-017 MOVE_UP/MOVE_DOWN: matching motor output high; travel counter counts TRAVEL_CYCLES cycles, then o_current_floor +1/-1 on same edge and counter reloads.
REQ-018 After each floor update, next cycle re-evaluates comparison: equal -> DOOR_OPEN (motors low that cycle); direction reversed -> go to opposite move state; unchanged -> continue.
REQ-019 Upper boundary: in MOVE_UP at NUM_FLOORS-1, floor SHALL NOT increment; pulse o_fault, go DOOR_OPEN. Lower boundary at 0 in MOVE_DOWN likewise; no wrap-around.
REQ-020 DOOR_OPEN: o_door_open=1 for DOOR_CYCLES cycles; motors low; then i_req_valid=1 -> FETCH, else IDLE.
REQ-021 Comparison inputs not one-hot (zero or multiple set) in SETTLE/MOVE states: pulse o_fault, motors low, -> IDLE.
REQ-022 o_motor_up and o_motor_down SHALL never both be 1; o_door_open=1 implies both motors 0.
REQ-023 Request arriving while busy SHALL wait; only fetched in FETCH.

Reset
REQ-024 i_rst_n low SHALL immediately force IDLE, o_current_floor=0, counters=0, all other outputs 0, including mid-travel or door-open.
REQ-025 Release SHALL be taken synchronously; first possible o_rd_en is second edge after release with i_req_valid=1.

Configuration
REQ-026 Macro ELEVATOR_FSM_DOOR_HOLD_EN: defined -> input i_door_hold (1 bit) exists; while high in DOOR_OPEN, door counter reloads to DOOR_CYCLES (door stays open). Undefined -> port absent, door closes strictly after DOOR_CYCLES.

Structure
REQ-027 Package elevator_pkg SHALL hold state enum, default FLOOR_WIDTH/NUM_FLOORS/TRAVEL_CYCLES/DOOR_CYCLES constants.
REQ-028 Sub-module elevator_timer (loadable down-counter, load/en inputs, done output) SHALL be instantiated once, shared by travel and door timing.

Verification
REQ-029 Reset, i_req_valid=1, controller target 5 from floor 0 -> o_rd_en one pulse, motor_up for 5x8=40 cycles, floor 5, door_open 16 cycles, IDLE.
REQ-030 From floor 5 target 2 -> motor_down, floor steps 4,3,2 each 8 cycles, then door_open.
REQ-031 Target equals current floor 3 -> SETTLE -> DOOR_OPEN directly, no motor activity, floor stays 3.
REQ-032 Force move_up at floor 15 -> o_fault pulse, floor stays 15, door_open.
REQ-033 Assert i_rst_n=0 mid-travel at floor 7 -> same cycle motors 0, floor 0, IDLE; no o_rd_en until request.
REQ-034 With ELEVATOR_FSM_DOOR_HOLD_EN, hold i_door_hold 30 cycles in DOOR_OPEN -> door_open lasts 30+16 cycles.
